// File: rtl/fuzz_campaign_scheduler.sv
`default_nettype none
// ============================================================================
// Module : fuzz_campaign_scheduler
// Brief  : Steers a satellite fuzzer through alternating random/mutated slices
//          over AHB-Lite and tallies the findings it reports.
// Rev    : 1.0  initial release
// ============================================================================
module fuzz_campaign_scheduler #(
    parameter int SLICE_CYCLES = 64,
    parameter int NUM_ROUNDS   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        stop_on_crash,
    output logic        hsel,
    output logic        hwrite,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [1:0]  cur_mode,
    output logic [7:0]  crash_cnt,
    output logic [7:0]  hang_cnt,
    output logic [7:0]  ovf_cnt,
    output logic [7:0]  mism_cnt,
    output logic [31:0] last_status
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CFG_RAND = 3'd1,
        S_RUN_RAND = 3'd2,
        S_CFG_MUT  = 3'd3,
        S_RUN_MUT  = 3'd4,
        S_CFG_IDLE = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    localparam logic [15:0] c_SLICE_LAST = 16'(SLICE_CYCLES - 1);
    localparam logic [7:0]  c_ROUND_LAST = 8'(NUM_ROUNDS - 1);

    state_t      state_q;
    logic [15:0] slice_q;
    logic [7:0]  round_q;
    logic [31:0] prev_q;
    logic [31:0] last_q;
    logic        busy_q;
    logic        done_q;
    logic        aborted_q;
    logic [1:0]  cur_mode_q;
    logic [7:0]  crash_q;
    logic [7:0]  hang_q;
    logic [7:0]  ovf_q;
    logic [7:0]  mism_q;

    logic        w_run;
    logic        w_sample;
    logic        w_edge;
    logic [15:0] w_tag;
    logic        w_stop;
    logic        w_slice_end;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // The first cycle of each slice lets the satellite settle into the new mode.
    assign w_run       = (state_q == S_RUN_RAND) || (state_q == S_RUN_MUT);
    assign w_sample    = w_run && (slice_q != 16'd0);
    assign w_edge      = (slice_q == 16'd1) || (hrdata != prev_q);
    assign w_tag       = hrdata[31:16];
    assign w_stop      = abort || (stop_on_crash && w_sample && (w_tag == 16'hDEAD));
    assign w_slice_end = (slice_q == c_SLICE_LAST);

    always_comb begin
        hsel   = 1'b0;
        hwrite = 1'b0;
        hwdata = 32'd0;
        case (state_q)
            S_CFG_RAND: begin hsel = 1'b1; hwrite = 1'b1; hwdata = 32'd1; end
            S_CFG_MUT:  begin hsel = 1'b1; hwrite = 1'b1; hwdata = 32'd2; end
            S_CFG_IDLE: begin hsel = 1'b1; hwrite = 1'b1; hwdata = 32'd0; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            slice_q    <= '0;
            round_q    <= '0;
            prev_q     <= '0;
            last_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            cur_mode_q <= 2'd0;
            crash_q    <= '0;
            hang_q     <= '0;
            ovf_q      <= '0;
            mism_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (w_sample) begin
                last_q <= hrdata;
                prev_q <= hrdata;
                if (w_edge) begin
                    case (w_tag)
                        16'hDEAD: crash_q <= sat_inc(crash_q);
                        16'hBEEF: hang_q  <= sat_inc(hang_q);
                        16'hC0DE: ovf_q   <= sat_inc(ovf_q);
                        16'hFFFF: mism_q  <= sat_inc(mism_q);
                        default: ;
                    endcase
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_CFG_RAND;
                        busy_q    <= 1'b1;
                        slice_q   <= '0;
                        round_q   <= '0;
                        last_q    <= '0;
                        aborted_q <= 1'b0;
                        crash_q   <= '0;
                        hang_q    <= '0;
                        ovf_q     <= '0;
                        mism_q    <= '0;
                    end
                end
                S_CFG_RAND, S_CFG_MUT: begin
                    cur_mode_q <= (state_q == S_CFG_RAND) ? 2'd1 : 2'd2;
                    slice_q    <= '0;
                    if (abort) begin
                        state_q   <= S_CFG_IDLE;
                        aborted_q <= 1'b1;
                    end else begin
                        state_q <= (state_q == S_CFG_RAND) ? S_RUN_RAND : S_RUN_MUT;
                    end
                end
                S_RUN_RAND, S_RUN_MUT: begin
                    slice_q <= slice_q + 16'd1;
                    if (w_stop) begin
                        state_q   <= S_CFG_IDLE;
                        aborted_q <= 1'b1;
                    end else if (w_slice_end) begin
                        if (state_q == S_RUN_RAND) begin
                            state_q <= S_CFG_MUT;
                        end else if (round_q == c_ROUND_LAST) begin
                            state_q <= S_CFG_IDLE;
                        end else begin
                            round_q <= round_q + 8'd1;
                            state_q <= S_CFG_RAND;
                        end
                    end
                end
                S_CFG_IDLE: begin
                    cur_mode_q <= 2'd0;
                    state_q    <= S_DONE;
                    done_q     <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign cur_mode    = cur_mode_q;
    assign crash_cnt   = crash_q;
    assign hang_cnt    = hang_q;
    assign ovf_cnt     = ovf_q;
    assign mism_cnt    = mism_q;
    assign last_status = last_q;

endmodule
`default_nettype wire

// File: tb/tb_fuzz_campaign_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_fuzz_campaign_scheduler
// Brief  : Self-checking bench; bus writes are scoreboarded against a queue.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fuzz_campaign_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, start2 = 1'b0, abort = 1'b0, stop_on_crash = 1'b0;
    logic [31:0] hrdata = 32'h1;
    logic        hsel, hwrite, busy, done, aborted;
    logic [31:0] hwdata, last_status;
    logic [1:0]  cur_mode;
    logic [7:0]  crash_cnt, hang_cnt, ovf_cnt, mism_cnt;
    logic        hsel2, hwrite2, busy2, done2, aborted2;
    logic [31:0] hwdata2, last_status2;
    logic [1:0]  cur_mode2;
    logic [7:0]  crash_cnt2, hang_cnt2, ovf_cnt2, mism_cnt2;

    typedef struct { int cyc; logic [31:0] data; } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0, errors = 0, cyc = 0;

    fuzz_campaign_scheduler #(.SLICE_CYCLES(4), .NUM_ROUNDS(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .stop_on_crash(stop_on_crash),
        .hsel(hsel), .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata),
        .busy(busy), .done(done), .aborted(aborted), .cur_mode(cur_mode),
        .crash_cnt(crash_cnt), .hang_cnt(hang_cnt), .ovf_cnt(ovf_cnt), .mism_cnt(mism_cnt),
        .last_status(last_status));

    fuzz_campaign_scheduler #(.SLICE_CYCLES(4), .NUM_ROUNDS(255)) dut_long (
        .clk(clk), .rst(rst), .start(start2), .abort(abort), .stop_on_crash(stop_on_crash),
        .hsel(hsel2), .hwrite(hwrite2), .hwdata(hwdata2), .hrdata(hrdata),
        .busy(busy2), .done(done2), .aborted(aborted2), .cur_mode(cur_mode2),
        .crash_cnt(crash_cnt2), .hang_cnt(hang_cnt2), .ovf_cnt(ovf_cnt2), .mism_cnt(mism_cnt2),
        .last_status(last_status2));

    always #5 clk = ~clk;

    // Bus monitor: every observed write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (hsel || hwrite)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bus_write unexpected at cycle %0d data %h", cyc, hwdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (cyc != mon_e.cyc || hwdata !== mon_e.data || hsel !== 1'b1 || hwrite !== 1'b1) begin
                    errors++;
                    $display("FAIL bus_write got cyc %0d data %h sel %b wr %b exp cyc %0d data %h",
                             cyc, hwdata, hsel, hwrite, mon_e.cyc, mon_e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_wr(input int c, input logic [31:0] d);
        wr_t e;
        e.cyc = c;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_full();
        push_wr(1, 32'd1); push_wr(6, 32'd2); push_wr(11, 32'd1); push_wr(16, 32'd2); push_wr(21, 32'd0);
    endtask

    function automatic logic [31:0] hr_val(input int mode, input int k);
        case (mode)
            1: return (k >= 2 && k <= 5) ? 32'hDEAD0001 : 32'h1;
            2: return (k >= 8) ? 32'hDEAD0002 : 32'h1;
            3: return k[0] ? 32'hBEEF0001 : 32'h1;
            4: begin
                if (k == 3 || k == 5) return 32'hC0DE0000;
                if (k == 4) return 32'hFFFF0000;
                if (k >= 8 && k <= 13) return 32'hFFFF1111;
                return 32'h1;
            end
            default: return 32'h1;
        endcase
    endfunction

    task automatic run_campaign(input int mode, input int abort_cyc, input bit hold_start,
                                input int max_cyc, output int done_cyc);
        done_cyc = -1;
        cyc = 0;
        hrdata = 32'h1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= max_cyc; k++) begin
            if (done === 1'b1) begin
                done_cyc = k;
                break;
            end
            hrdata = hr_val(mode, k);
            abort = (k == abort_cyc);
            start = hold_start && (k >= 2) && (k <= 5);
            tick();
        end
        abort = 1'b0;
        start = 1'b0;
        hrdata = 32'h1;
        tick();
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s writes_missing got %0d pending exp 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({hsel, hwrite, hwdata, busy, done, aborted, cur_mode, crash_cnt, hang_cnt, ovf_cnt,
             mism_cnt, last_status} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy %b sel %b data %h status %h exp all 0",
                     busy, hsel, hwdata, last_status);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_normal();
        int d;
        push_full();
        run_campaign(0, -1, 1'b0, 40, d);
        checks++; if (d != 22) begin errors++; $display("FAIL normal_done_cycle got %0d exp 22", d); end
        checks++;
        if ({crash_cnt, hang_cnt, ovf_cnt, mism_cnt} !== 32'd0) begin
            errors++; $display("FAIL normal_counters got %h exp 0", {crash_cnt, hang_cnt, ovf_cnt, mism_cnt});
        end
        checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL normal_aborted got %b exp 0", aborted); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL normal_idle_busy got %b exp 0", busy); end
        checks++; if (last_status !== 32'h1) begin errors++; $display("FAIL normal_status got %h exp 1", last_status); end
        check_queue_empty("normal");
    endtask

    task automatic test_crash_count();
        int d;
        push_full();
        run_campaign(1, -1, 1'b0, 40, d);
        checks++; if (d != 22) begin errors++; $display("FAIL crash_done_cycle got %0d exp 22", d); end
        checks++; if (crash_cnt !== 8'd1) begin errors++; $display("FAIL crash_edge_count got %0d exp 1", crash_cnt); end
        checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL crash_aborted got %b exp 0", aborted); end
        hrdata = 32'hDEAD0003;
        repeat (3) tick();
        checks++;
        if (crash_cnt !== 8'd1 || last_status !== 32'h1) begin
            errors++; $display("FAIL crash_hold_idle got %0d/%h exp 1/00000001", crash_cnt, last_status);
        end
        hrdata = 32'h1;
        check_queue_empty("crash");
    endtask

    task automatic test_crash_stop();
        int d;
        stop_on_crash = 1'b1;
        push_wr(1, 32'd1); push_wr(6, 32'd2); push_wr(9, 32'd0);
        run_campaign(2, -1, 1'b0, 40, d);
        stop_on_crash = 1'b0;
        checks++; if (d != 10) begin errors++; $display("FAIL stop_done_cycle got %0d exp 10", d); end
        checks++; if (crash_cnt !== 8'd1) begin errors++; $display("FAIL stop_crash_cnt got %0d exp 1", crash_cnt); end
        checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL stop_aborted got %b exp 1", aborted); end
        checks++; if (last_status !== 32'hDEAD0002) begin errors++; $display("FAIL stop_status got %h exp dead0002", last_status); end
        checks++; if (cur_mode !== 2'd0) begin errors++; $display("FAIL stop_cur_mode got %0d exp 0", cur_mode); end
        check_queue_empty("stop");
    endtask

    task automatic test_hang_alt();
        int d;
        push_full();
        run_campaign(3, -1, 1'b0, 40, d);
        checks++; if (d != 22) begin errors++; $display("FAIL hang_done_cycle got %0d exp 22", d); end
        checks++; if (hang_cnt !== 8'd6) begin errors++; $display("FAIL hang_alt_count got %0d exp 6", hang_cnt); end
        checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL hang_aborted_cleared got %b exp 0", aborted); end
        checks++; if (crash_cnt !== 8'd0) begin errors++; $display("FAIL hang_crash_cleared got %0d exp 0", crash_cnt); end
        check_queue_empty("hang");
    endtask

    task automatic test_classify();
        int d;
        push_full();
        run_campaign(4, -1, 1'b0, 40, d);
        checks++; if (ovf_cnt !== 8'd2) begin errors++; $display("FAIL classify_ovf got %0d exp 2", ovf_cnt); end
        checks++; if (mism_cnt !== 8'd3) begin errors++; $display("FAIL classify_mism got %0d exp 3", mism_cnt); end
        checks++; if (hang_cnt !== 8'd0) begin errors++; $display("FAIL classify_hang got %0d exp 0", hang_cnt); end
        check_queue_empty("classify");
    endtask

    task automatic test_abort();
        int d;
        push_wr(1, 32'd1); push_wr(4, 32'd0);
        run_campaign(0, 3, 1'b1, 40, d);
        checks++; if (d != 5) begin errors++; $display("FAIL abort_done_cycle got %0d exp 5", d); end
        checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL abort_flag got %b exp 1", aborted); end
        repeat (2) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_ignored got busy %b exp 0", busy); end
        check_queue_empty("abort");
    endtask

    task automatic test_reset_mid();
        int d;
        push_wr(1, 32'd1); push_wr(6, 32'd2);
        cyc = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            hrdata = hr_val(1, k);
            tick();
        end
        checks++;
        if (busy !== 1'b1 || crash_cnt !== 8'd1) begin
            errors++; $display("FAIL midrst_pre got busy %b crash %0d exp 1/1", busy, crash_cnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({hsel, hwrite, hwdata, busy, done, aborted, cur_mode, crash_cnt, hang_cnt, ovf_cnt,
             mism_cnt, last_status} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs got busy %b crash %0d mode %0d status %h exp all 0",
                     busy, crash_cnt, cur_mode, last_status);
        end
        hrdata = 32'h1;
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_queue_empty("midrst_pre");
        push_full();
        run_campaign(0, -1, 1'b0, 40, d);
        checks++; if (d != 22) begin errors++; $display("FAIL midrst_clean_done got %0d exp 22", d); end
        checks++; if (crash_cnt !== 8'd0) begin errors++; $display("FAIL midrst_clean_crash got %0d exp 0", crash_cnt); end
        check_queue_empty("midrst");
    endtask

    task automatic test_hang_saturate();
        int d, model;
        d = -1;
        model = 0;
        cyc = 0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 1; k <= 3000; k++) begin
            if (k == 201) begin
                checks++;
                if (hang_cnt2 !== 8'(model)) begin
                    errors++; $display("FAIL sat_mid_count got %0d exp %0d", hang_cnt2, model);
                end
            end
            if (done2 === 1'b1) begin
                d = k;
                break;
            end
            hrdata = hr_val(3, k);
            if (k >= 3 && (k % 5 == 0 || k % 5 == 3 || k % 5 == 4) && k[0] && model < 255) model++;
            tick();
        end
        hrdata = 32'h1;
        checks++; if (d != 2552) begin errors++; $display("FAIL sat_done_cycle got %0d exp 2552", d); end
        checks++;
        if (hang_cnt2 !== 8'd255 || model != 255) begin
            errors++; $display("FAIL sat_final_count got %0d exp 255 (model %0d)", hang_cnt2, model);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_crash_count();
        test_crash_stop();
        test_hang_alt();
        test_classify();
        test_abort();
        test_reset_mid();
        test_hang_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
